// File: rtl/demux_l1.sv
// Layer-1 receive demultiplexer: each of two lanes carries interleaved even/odd
// byte pairs, which are reassembled and presented together on two output buses.
module demux_l1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Entrada0,
    input  logic             validEntrada0,
    input  logic [WIDTH-1:0] Entrada1,
    input  logic             validEntrada1,
    output logic [WIDTH-1:0] Salida0,
    output logic [WIDTH-1:0] Salida1,
    output logic [WIDTH-1:0] Salida2,
    output logic [WIDTH-1:0] Salida3,
    output logic             validSalida0,
    output logic             validSalida1,
    output logic             validSalida2,
    output logic             validSalida3
);

    logic [1:0]       vld_p0;
    logic [WIDTH-1:0] data_p0 [2];

    assign vld_p0     = {validEntrada1, validEntrada0};
    assign data_p0[0] = Entrada0;
    assign data_p0[1] = Entrada1;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic             phase;
        logic [WIDTH-1:0] hold;
        logic [WIDTH-1:0] even_p1;
        logic [WIDTH-1:0] odd_p1;
        logic             vld_p1;

        // p0 -> p1: the even word parks in hold until its odd partner arrives
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                phase   <= 1'b0;
                hold    <= '0;
                even_p1 <= '0;
                odd_p1  <= '0;
                vld_p1  <= 1'b0;
            end else begin
                vld_p1 <= 1'b0;
                if (vld_p0[g]) begin
                    if (!phase) begin
                        hold  <= data_p0[g];
                        phase <= 1'b1;
                    end else begin
                        even_p1 <= hold;
                        odd_p1  <= data_p0[g];
                        vld_p1  <= 1'b1;
                        phase   <= 1'b0;
                    end
                end
            end
        end
    end

    assign Salida0      = g_lane[0].even_p1;
    assign Salida1      = g_lane[0].odd_p1;
    assign validSalida0 = g_lane[0].vld_p1;
    assign validSalida1 = g_lane[0].vld_p1;
    assign Salida2      = g_lane[1].even_p1;
    assign Salida3      = g_lane[1].odd_p1;
    assign validSalida2 = g_lane[1].vld_p1;
    assign validSalida3 = g_lane[1].vld_p1;

endmodule

// File: tb/tb_demux_l1.sv
// Scoreboard bench for demux_l1: directed lane traffic pushes expected pairs,
// a negedge monitor pops and checks them against the output buses.
module tb_demux_l1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Entrada0, Entrada1;
    logic       validEntrada0, validEntrada1;
    logic [7:0] Salida0, Salida1, Salida2, Salida3;
    logic       validSalida0, validSalida1, validSalida2, validSalida3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] ev;
        logic [7:0] od;
        int         due;
    } pair_t;

    pair_t q0[$];
    pair_t q1[$];

    demux_l1 #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .Entrada0(Entrada0), .validEntrada0(validEntrada0),
        .Entrada1(Entrada1), .validEntrada1(validEntrada1),
        .Salida0(Salida0), .Salida1(Salida1), .Salida2(Salida2), .Salida3(Salida3),
        .validSalida0(validSalida0), .validSalida1(validSalida1),
        .validSalida2(validSalida2), .validSalida3(validSalida3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h expected=%02h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of input right after the rising edge.
    task automatic drive(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        @(posedge clk);
        #1;
        validEntrada0 = v0; Entrada0 = d0;
        validEntrada1 = v1; Entrada1 = d1;
    endtask

    // Call right after the drive that issues the odd word of a pair.
    task automatic expect_pair(input int lane, input logic [7:0] ev, input logic [7:0] od);
        pair_t p;
        p.ev = ev; p.od = od; p.due = cyc + 1;
        if (lane == 0) q0.push_back(p);
        else           q1.push_back(p);
    endtask

    task automatic mon_lane(input int lane, input logic va, input logic vb,
                            input logic [7:0] ev, input logic [7:0] od);
        pair_t p;
        int    n;
        string tag;
        tag = (lane == 0) ? "lane0" : "lane1";
        check8({tag, "_valid_pair_equal"}, {7'd0, vb}, {7'd0, va});
        n = (lane == 0) ? q0.size() : q1.size();
        if (va) begin
            checks++;
            if (n == 0) begin
                errors++;
                $display("FAIL %s_unexpected_valid actual=1 expected=0 (cycle %0d)", tag, cyc);
                return;
            end
            p = (lane == 0) ? q0.pop_front() : q1.pop_front();
            if (p.due != cyc) begin
                errors++;
                $display("FAIL %s_latency actual_cycle=%0d expected_cycle=%0d", tag, cyc, p.due);
            end
            check8({tag, "_even"}, ev, p.ev);
            check8({tag, "_odd"}, od, p.od);
        end else if (n != 0) begin
            p = (lane == 0) ? q0[0] : q1[0];
            if (p.due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL %s_missing_pair actual_valid=0 expected_valid=1 (cycle %0d)", tag, cyc);
                if (lane == 0) void'(q0.pop_front());
                else           void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon_lane(0, validSalida0, validSalida1, Salida0, Salida1);
        mon_lane(1, validSalida2, validSalida3, Salida2, Salida3);
    end

    task automatic check_all_zero(input string name);
        check8({name, "_Salida0"}, Salida0, 8'h00);
        check8({name, "_Salida1"}, Salida1, 8'h00);
        check8({name, "_Salida2"}, Salida2, 8'h00);
        check8({name, "_Salida3"}, Salida3, 8'h00);
        check8({name, "_valids"},
               {4'd0, validSalida3, validSalida2, validSalida1, validSalida0}, 8'h00);
    endtask

    initial begin
        reset = 1'b1;
        validEntrada0 = 1'b0; Entrada0 = 8'h00;
        validEntrada1 = 1'b0; Entrada1 = 8'h00;
        #2;
        check_all_zero("reset_state");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Back-to-back lane 0.
        drive(1, 8'hA1, 0, 8'h00);
        drive(1, 8'hB2, 0, 8'h00); expect_pair(0, 8'hA1, 8'hB2);
        drive(1, 8'hC3, 0, 8'h00);
        drive(1, 8'hD4, 0, 8'h00); expect_pair(0, 8'hC3, 8'hD4);
        repeat (2) drive(0, 8'h00, 0, 8'h00);

        // Gap inside a lane 1 pair.
        drive(0, 8'h00, 1, 8'h11);
        repeat (3) drive(0, 8'h00, 0, 8'h00);
        drive(0, 8'h00, 1, 8'h22); expect_pair(1, 8'h11, 8'h22);
        repeat (2) drive(0, 8'h00, 0, 8'h00);

        // Independent lanes with offset phases.
        drive(1, 8'h01, 0, 8'h00);
        drive(1, 8'h02, 1, 8'h03); expect_pair(0, 8'h01, 8'h02);
        drive(0, 8'h00, 1, 8'h04); expect_pair(1, 8'h03, 8'h04);
        repeat (2) drive(0, 8'h00, 0, 8'h00);

        // Asynchronous reset while both lanes present a pair.
        drive(1, 8'h3C, 1, 8'h5A);
        drive(1, 8'hC3, 1, 8'hA5); expect_pair(0, 8'h3C, 8'hC3); expect_pair(1, 8'h5A, 8'hA5);
        drive(0, 8'h00, 0, 8'h00);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Reset mid-pair discards the held even word.
        drive(1, 8'h55, 0, 8'h00);
        drive(0, 8'h00, 0, 8'h00);
        #3 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        drive(1, 8'h66, 0, 8'h00);
        drive(1, 8'h77, 0, 8'h00); expect_pair(0, 8'h66, 8'h77);
        repeat (3) drive(0, 8'h00, 0, 8'h00);
        @(posedge clk);

        check8("lane0_queue_drained", 8'(q0.size()), 8'd0);
        check8("lane1_queue_drained", 8'(q1.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
